// File: rtl/matrix_operand_fetch_if.sv
// Operand-fetch handshake bundle: request/stall/register-file read port on one side,
// assembled operands and multiplier launch/status on the other.
interface matrix_operand_fetch_if;
  logic        is_matrix_mult;
  logic        stall;
  logic [7:0]  rddata;
  logic        mult_done;
  logic [2:0]  rdreg;
  logic        rd_en;
  logic [31:0] A;
  logic [31:0] B;
  logic        mult_start;
  logic        busy;
  logic        fetch_done;
  logic        fetch_error;

  // Requesting side: pipeline, register file and multiplier.
  modport master (
    output is_matrix_mult, stall, rddata, mult_done,
    input  rdreg, rd_en, A, B, mult_start, busy, fetch_done, fetch_error
  );

  // Fetch engine side.
  modport slave (
    input  is_matrix_mult, stall, rddata, mult_done,
    output rdreg, rd_en, A, B, mult_start, busy, fetch_done, fetch_error
  );
endinterface

// File: rtl/matrix_operand_fetch.sv
// Fetches operands A and B one byte per cycle from the register file, then launches the multiplier.
// Define MATRIX_FETCH_TIMEOUT_EN to add a WAIT watchdog that aborts with a fetch_error pulse.
module matrix_operand_fetch #(
  parameter logic [2:0] A_BASE         = 3'd0,
  parameter logic [2:0] B_BASE         = 3'd4,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input logic                   clk,
  input logic                   reset,
  matrix_operand_fetch_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    LAUNCH  = 3'd3,
    WAIT    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        done_q, done_d;
  logic [2:0]  a_addr, b_addr;

`ifdef MATRIX_FETCH_TIMEOUT_EN
  logic [7:0]  wd_q, wd_d;
  logic        err_q, err_d;
`endif

  // Register indices wrap modulo 8 through the 3-bit sum.
  always_comb begin
    a_addr = A_BASE + {1'b0, idx_q};
    b_addr = B_BASE + {1'b0, idx_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
`ifdef MATRIX_FETCH_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
`ifdef MATRIX_FETCH_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef MATRIX_FETCH_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.is_matrix_mult) begin
          state_d = FETCH_A;
          idx_d   = '0;
        end
      end

      FETCH_A: begin
        if (!bus.stall) begin
          a_d[{idx_q, 3'b000} +: 8] = bus.rddata;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = FETCH_B;
        end
      end

      FETCH_B: begin
        if (!bus.stall) begin
          b_d[{idx_q, 3'b000} +: 8] = bus.rddata;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = LAUNCH;
        end
      end

      LAUNCH: begin
        state_d = WAIT;
`ifdef MATRIX_FETCH_TIMEOUT_EN
        wd_d    = '0;
`endif
      end

      WAIT: begin
        if (bus.mult_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef MATRIX_FETCH_TIMEOUT_EN
        // The count reaches TIMEOUT_CYCLES on this edge, so abort now.
        else if (wd_q == TIMEOUT_CYCLES - 8'd1) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rdreg = '0;
    bus.rd_en = 1'b0;
    case (state_q)
      FETCH_A: begin
        bus.rdreg = a_addr;
        bus.rd_en = !bus.stall;
      end
      FETCH_B: begin
        bus.rdreg = b_addr;
        bus.rd_en = !bus.stall;
      end
      default: ;
    endcase

    bus.A          = a_q;
    bus.B          = b_q;
    bus.mult_start = (state_q == LAUNCH);
    bus.busy       = (state_q != IDLE);
    bus.fetch_done = done_q;
`ifdef MATRIX_FETCH_TIMEOUT_EN
    bus.fetch_error = err_q;
`else
    bus.fetch_error = 1'b0;
`endif
  end

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// Scoreboard bench: two fetch engines (default bases and A_BASE=6/B_BASE=2) run in lockstep on
// one shared register-file image; expected operands are queued per request and checked at launch.
module tb_matrix_operand_fetch;

  localparam logic [31:0] EXP_A0 = 32'h44332211;
  localparam logic [31:0] EXP_B0 = 32'h88776655;
  localparam logic [31:0] EXP_A1 = 32'h22118877;
  localparam logic [31:0] EXP_B1 = 32'h66554433;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic is_mm     = 1'b0;
  logic stall     = 1'b0;
  logic mult_done = 1'b0;
  logic [7:0] regs [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  matrix_operand_fetch_if ifa ();
  matrix_operand_fetch_if ifb ();

  assign ifa.is_matrix_mult = is_mm;
  assign ifa.stall          = stall;
  assign ifa.mult_done      = mult_done;
  assign ifa.rddata         = regs[ifa.rdreg];
  assign ifb.is_matrix_mult = is_mm;
  assign ifb.stall          = stall;
  assign ifb.mult_done      = mult_done;
  assign ifb.rddata         = regs[ifb.rdreg];

  matrix_operand_fetch #(.A_BASE(3'd0), .B_BASE(3'd4), .TIMEOUT_CYCLES(8'd8)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  matrix_operand_fetch #(.A_BASE(3'd6), .B_BASE(3'd2), .TIMEOUT_CYCLES(8'd8)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    int unsigned launch_edge;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp    = 0;
  int unsigned n_err    = 0;
  int unsigned edge_cnt = 0;
  int unsigned launches = 0;
  int unsigned dones    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    if (ifa.mult_start === 1'b1) begin
      exp_t e;
      launches++;
      check_eq("launch_pair", ifb.mult_start, 1);
      check_eq("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("A_base0", ifa.A, e.a0);
        check_eq("B_base0", ifa.B, e.b0);
        check_eq("A_base6", ifb.A, e.a1);
        check_eq("B_base2", ifb.B, e.b1);
        check_eq("launch_edge", edge_cnt + 1, e.launch_edge);
      end
    end
    if (ifa.fetch_done === 1'b1) dones++;
  end

  // Drives a request and walks it through all capture cycles; ends on the LAUNCH cycle.
  task automatic start_op(input int unsigned stall_at, input int unsigned stall_len, input bit noise);
    exp_t e;
    is_mm = 1'b1;
    @(negedge clk);
    is_mm = 1'b0;
    e.a0 = EXP_A0; e.b0 = EXP_B0; e.a1 = EXP_A1; e.b1 = EXP_B1;
    e.launch_edge = edge_cnt + 9 + stall_len;
    sb.push_back(e);
    check_eq("busy_fetch", ifa.busy, 1);
    for (int unsigned c = 1; c <= 8 + stall_len; c++) begin
      stall     = (c >= stall_at) && (c < stall_at + stall_len);
      mult_done = noise && (c == 2);
      is_mm     = noise && (c == 7);
      #1;
      if (stall) begin
        check_eq("rd_en_stall", ifa.rd_en, 0);
        check_eq("rdreg_stall_a", ifa.rdreg, stall_at - 1);
        check_eq("rdreg_stall_b", ifb.rdreg, (6 + stall_at - 1) % 8);
      end else if (c == 1) begin
        check_eq("rd_en_first", ifa.rd_en, 1);
        check_eq("rdreg_first_a", ifa.rdreg, 0);
        check_eq("rdreg_first_b", ifb.rdreg, 6);
      end
      @(negedge clk);
    end
    stall = 1'b0; mult_done = 1'b0; is_mm = 1'b0;
    check_eq("mult_start", ifa.mult_start, 1);
    check_eq("rd_en_launch", ifa.rd_en, 0);
    check_eq("rdreg_launch", ifa.rdreg, 0);
  endtask

  // Waits done_delay cycles in WAIT (with stall asserted, which must not matter), then completes.
  task automatic finish_op(input int unsigned done_delay);
    int unsigned d0;
    d0 = dones;
    stall = 1'b1;
    repeat (done_delay) @(negedge clk);
    stall = 1'b0;
    check_eq("busy_wait", ifa.busy, 1);
    check_eq("mult_start_once", ifa.mult_start, 0);
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
    check_eq("fetch_done_a", ifa.fetch_done, 1);
    check_eq("fetch_done_b", ifb.fetch_done, 1);
    check_eq("busy_after", ifa.busy, 0);
    check_eq("fetch_error", ifa.fetch_error, 0);
    check_eq("A_stable", ifa.A, EXP_A0);
    check_eq("B_stable", ifb.B, EXP_B1);
    @(negedge clk);
    check_eq("fetch_done_pulse", ifa.fetch_done, 0);
    check_eq("done_count", dones - d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int unsigned n;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", ifa.busy, 0);
    check_eq("rst_rd_en", ifa.rd_en, 0);
    check_eq("rst_rdreg", ifa.rdreg, 0);
    check_eq("rst_A", ifa.A, 0);
    check_eq("rst_B", ifa.B, 0);
    check_eq("rst_mult_start", ifa.mult_start, 0);
    check_eq("rst_fetch_done", ifa.fetch_done, 0);
    check_eq("rst_fetch_error", ifa.fetch_error, 0);
    reset = 1'b0;
    @(negedge clk);

    start_op(0, 0, 1'b0);
    finish_op(3);
    start_op(3, 2, 1'b0);
    finish_op(3);
    start_op(0, 0, 1'b1);
    finish_op(3);
    repeat (12) @(negedge clk);
    check_eq("no_restart_busy", ifa.busy, 0);
    check_eq("launch_count", launches, 3);

    // Abort mid-fetch: reset sampled at request edge + 5.
    is_mm = 1'b1;
    @(negedge clk);
    is_mm = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", ifa.busy, 0);
    check_eq("abort_rd_en", ifa.rd_en, 0);
    check_eq("abort_rdreg", ifb.rdreg, 0);
    check_eq("abort_A", ifa.A, 0);
    check_eq("abort_B", ifb.B, 0);
    check_eq("abort_mult_start", ifa.mult_start, 0);
    check_eq("abort_fetch_done", ifa.fetch_done, 0);
    repeat (12) @(negedge clk);
    check_eq("abort_no_launch", launches, 3);
    check_eq("abort_no_done", dones, 3);

    start_op(0, 0, 1'b0);
    finish_op(1);

`ifdef MATRIX_FETCH_TIMEOUT_EN
    start_op(0, 0, 1'b0);
    n = 0;
    while (ifa.fetch_error !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_cycle", n, 9);
    check_eq("timeout_err_b", ifb.fetch_error, 1);
    check_eq("timeout_busy", ifa.busy, 0);
    check_eq("timeout_no_done", ifa.fetch_done, 0);
    @(negedge clk);
    check_eq("timeout_pulse", ifa.fetch_error, 0);
    check_eq("timeout_done_count", dones, 4);
    check_eq("final_launches", launches, 5);
`else
    check_eq("final_launches", launches, 4);
`endif
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
